// File: rtl/life_pkg.sv
// Shared constants and types for the Game of Life generation engine.
package life_pkg;

  localparam int ROWS  = 15;
  localparam int COLS  = 20;
  localparam int ROW_W = $clog2(ROWS);
  localparam int COL_W = $clog2(COLS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  typedef logic [2:0] colour_t;

  localparam colour_t BLACK   = 3'd0;
  localparam colour_t BLUE    = 3'd1;
  localparam colour_t GREEN   = 3'd2;
  localparam colour_t CYAN    = 3'd3;
  localparam colour_t RED     = 3'd4;
  localparam colour_t MAGENTA = 3'd5;
  localparam colour_t YELLOW  = 3'd6;
  localparam colour_t WHITE   = 3'd7;

  function automatic logic [3:0] ones3(input logic [2:0] b);
    return {3'b000, b[0]} + {3'b000, b[1]} + {3'b000, b[2]};
  endfunction

endpackage

// File: rtl/life_row_next.sv
// Combinational Life rule for one row, given the rows above, at and below it.
module life_row_next
  import life_pkg::*;
#(
  parameter int COLS = life_pkg::COLS,
  parameter bit WRAP = 1'b1
)(
  input  logic [COLS-1:0] prev_i,
  input  logic [COLS-1:0] cur_i,
  input  logic [COLS-1:0] next_i,
  output logic [COLS-1:0] row_o
);

  logic [COLS+1:0] prev_x;
  logic [COLS+1:0] cur_x;
  logic [COLS+1:0] next_x;
  logic [3:0]      n;

  // Pad each row with its edge neighbours so column k sees bits k..k+2.
  assign prev_x = {(WRAP ? prev_i[0] : 1'b0), prev_i, (WRAP ? prev_i[COLS-1] : 1'b0)};
  assign cur_x  = {(WRAP ? cur_i[0]  : 1'b0), cur_i,  (WRAP ? cur_i[COLS-1]  : 1'b0)};
  assign next_x = {(WRAP ? next_i[0] : 1'b0), next_i, (WRAP ? next_i[COLS-1] : 1'b0)};

  always_comb begin
    row_o = '0;
    n     = '0;
    for (int k = 0; k < COLS; k++) begin
      n = ones3(prev_x[k +: 3]) + ones3(next_x[k +: 3])
        + {3'b000, cur_x[k]} + {3'b000, cur_x[k+2]};
      row_o[k] = (n == 4'd3) || (cur_i[k] && (n == 4'd2));
    end
  end

endmodule

// File: rtl/life_engine.sv
// Streams one generation from the read buffer through a 3-row window and
// writes the next generation into the write buffer.
//   state | meaning
//   IDLE  | waiting for i_start
//   FILL  | reading until the window holds rows ROWS-1, 0, 1
//   RUN   | one row written per cycle, reads continue
//   DONE  | single-cycle o_done pulse
module life_engine
  import life_pkg::*;
#(
  parameter int ROWS = life_pkg::ROWS,
  parameter int COLS = life_pkg::COLS,
  parameter bit WRAP = 1'b1,
  parameter int RW   = 4
)(
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_start,
  output logic            o_busy,
  output logic            o_done,
  output logic            o_rd_en,
  output logic [RW-1:0]   o_rd_addr,
  input  logic [COLS-1:0] i_rd_data,
  output logic            o_wr_en,
  output logic [RW-1:0]   o_wr_addr,
  output logic [COLS-1:0] o_wr_data
);

  localparam int              RD_W     = $clog2(ROWS + 3);
  localparam logic [RW-1:0]   LAST_ROW = RW'(ROWS - 1);
  localparam logic [RD_W-1:0] N_READS  = RD_W'(ROWS + 2);
  localparam logic [RD_W-1:0] FILL_END = RD_W'(ROWS - 1);
  localparam logic [RD_W-1:0] ONE_LEFT = RD_W'(1);

  state_e            state_q, state_d;
  logic [RD_W-1:0]   rd_left_q, rd_left_d;
  logic [RW-1:0]     rd_addr_q, rd_addr_d;
  logic [RW-1:0]     wr_addr_q, wr_addr_d;
  logic              rd_vld_q;
  logic              rd_edge_q;
  logic [COLS-1:0]   prev_q, cur_q, next_q;
  logic [COLS-1:0]   shift_in;
  logic              rd_en;
  logic              wr_en;

  always_comb begin
    state_d   = state_q;
    rd_left_d = rd_left_q;
    rd_addr_d = rd_addr_q;
    wr_addr_d = wr_addr_q;
    rd_en     = 1'b0;
    wr_en     = 1'b0;
    o_done    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d   = ST_FILL;
          rd_left_d = N_READS;
          rd_addr_d = LAST_ROW;
        end
      end
      ST_FILL: begin
        rd_en = 1'b1;
        // third row lands in the window at the end of this cycle
        if (rd_left_q == FILL_END) begin
          state_d   = ST_RUN;
          wr_addr_d = '0;
        end
      end
      ST_RUN: begin
        rd_en = (rd_left_q != '0);
        wr_en = 1'b1;
        if (wr_addr_q == LAST_ROW) begin
          state_d = ST_DONE;
        end else begin
          wr_addr_d = wr_addr_q + 1'b1;
        end
      end
      ST_DONE: begin
        o_done  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Address only advances while more reads remain, so it holds after the last one.
    if (rd_en) begin
      rd_left_d = rd_left_q - 1'b1;
      if (rd_left_q != ONE_LEFT) begin
        rd_addr_d = (rd_addr_q == LAST_ROW) ? '0 : rd_addr_q + 1'b1;
      end
    end
  end

  assign shift_in = (!WRAP && rd_edge_q) ? '0 : i_rd_data;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ST_IDLE;
      rd_left_q <= '0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      rd_vld_q  <= 1'b0;
      rd_edge_q <= 1'b0;
      prev_q    <= '0;
      cur_q     <= '0;
      next_q    <= '0;
    end else begin
      state_q   <= state_d;
      rd_left_q <= rd_left_d;
      rd_addr_q <= rd_addr_d;
      wr_addr_q <= wr_addr_d;
      rd_vld_q  <= rd_en;
      rd_edge_q <= rd_en && ((rd_left_q == N_READS) || (rd_left_q == ONE_LEFT));
      if (rd_vld_q) begin
        prev_q <= cur_q;
        cur_q  <= next_q;
        next_q <= shift_in;
      end
    end
  end

  life_row_next #(
    .COLS (COLS),
    .WRAP (WRAP)
  ) u_row_next (
    .prev_i (prev_q),
    .cur_i  (cur_q),
    .next_i (next_q),
    .row_o  (o_wr_data)
  );

  assign o_busy    = (state_q != ST_IDLE);
  assign o_rd_en   = rd_en;
  assign o_rd_addr = rd_addr_q;
  assign o_wr_en   = wr_en;
  assign o_wr_addr = wr_addr_q;

endmodule

// File: tb/tb_life_engine.sv
// Bench for life_engine: a toroidal and a dead-edge instance share one
// read buffer and are checked against a cell-by-cell Life model.
module tb_life_engine;

  localparam int ROWS = 15;
  localparam int COLS = 20;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic start = 1'b0;

  always #5 clk = ~clk;

  logic            w_busy, w_done, w_rd_en, w_wr_en;
  logic [3:0]      w_rd_addr, w_wr_addr;
  logic [COLS-1:0] w_rd_data = '0;
  logic [COLS-1:0] w_wr_data;
  logic            z_busy, z_done, z_rd_en, z_wr_en;
  logic [3:0]      z_rd_addr, z_wr_addr;
  logic [COLS-1:0] z_rd_data = '0;
  logic [COLS-1:0] z_wr_data;

  life_engine #(.WRAP(1'b1)) dut_w (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
    .o_busy(w_busy), .o_done(w_done),
    .o_rd_en(w_rd_en), .o_rd_addr(w_rd_addr), .i_rd_data(w_rd_data),
    .o_wr_en(w_wr_en), .o_wr_addr(w_wr_addr), .o_wr_data(w_wr_data)
  );

  life_engine #(.WRAP(1'b0)) dut_z (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
    .o_busy(z_busy), .o_done(z_done),
    .o_rd_en(z_rd_en), .o_rd_addr(z_rd_addr), .i_rd_data(z_rd_data),
    .o_wr_en(z_wr_en), .o_wr_addr(z_wr_addr), .o_wr_data(z_wr_data)
  );

  logic [COLS-1:0] grid   [ROWS];
  logic [COLS-1:0] wr_cap [2][ROWS];
  logic [COLS-1:0] orig   [ROWS];
  int n_chk = 0;
  int n_err = 0;

  always @(posedge clk) begin
    if (w_rd_en) w_rd_data <= grid[w_rd_addr];
    if (z_rd_en) z_rd_data <= grid[z_rd_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [COLS-1:0] model_row(input int r, input bit wrap);
    logic [COLS-1:0] res;
    int n, rr, cc;
    res = '0;
    for (int c = 0; c < COLS; c++) begin
      n = 0;
      for (int dr = -1; dr <= 1; dr++) begin
        for (int dc = -1; dc <= 1; dc++) begin
          if (dr != 0 || dc != 0) begin
            rr = r + dr;
            cc = c + dc;
            if (wrap) begin
              rr = (rr + ROWS) % ROWS;
              cc = (cc + COLS) % COLS;
              n += int'(grid[rr][cc]);
            end else if (rr >= 0 && rr < ROWS && cc >= 0 && cc < COLS) begin
              n += int'(grid[rr][cc]);
            end
          end
        end
      end
      res[c] = (n == 3) || (grid[r][c] && n == 2);
    end
    return res;
  endfunction

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_w_busy"}, w_busy, 0);   chk({tag, "_z_busy"}, z_busy, 0);
    chk({tag, "_w_done"}, w_done, 0);   chk({tag, "_z_done"}, z_done, 0);
    chk({tag, "_w_rd_en"}, w_rd_en, 0); chk({tag, "_z_rd_en"}, z_rd_en, 0);
    chk({tag, "_w_wr_en"}, w_wr_en, 0); chk({tag, "_z_wr_en"}, z_wr_en, 0);
    chk({tag, "_w_rd_addr"}, w_rd_addr, 0); chk({tag, "_z_rd_addr"}, z_rd_addr, 0);
    chk({tag, "_w_wr_addr"}, w_wr_addr, 0); chk({tag, "_z_wr_addr"}, z_wr_addr, 0);
    chk({tag, "_w_wr_data"}, w_wr_data, 0); chk({tag, "_z_wr_data"}, z_wr_data, 0);
  endtask

  // Caller must be at a falling edge; start is sampled on the next rising edge (cycle 0).
  task automatic run_gen(input string name, input bit glitch, input int abort_at);
    logic [COLS-1:0] exp_r [2][ROWS];
    int              nwr   [2];
    logic            busy, done, rde, wre;
    logic [3:0]      rda, wra;
    logic [COLS-1:0] wrd;
    string           tg;
    for (int r = 0; r < ROWS; r++) begin
      exp_r[0][r] = model_row(r, 1'b1);
      exp_r[1][r] = model_row(r, 1'b0);
    end
    nwr[0] = 0;
    nwr[1] = 0;
    start = 1'b1;
    for (int c = 1; c <= 21; c++) begin
      @(negedge clk);
      start = glitch && (c == 3 || c == 20);
      for (int d = 0; d < 2; d++) begin
        busy = d ? z_busy    : w_busy;
        done = d ? z_done    : w_done;
        rde  = d ? z_rd_en   : w_rd_en;
        rda  = d ? z_rd_addr : w_rd_addr;
        wre  = d ? z_wr_en   : w_wr_en;
        wra  = d ? z_wr_addr : w_wr_addr;
        wrd  = d ? z_wr_data : w_wr_data;
        tg   = $sformatf("%s_%s_c%0d", name, d ? "z" : "w", c);
        chk({tg, "_busy"}, busy, (c <= 20));
        chk({tg, "_done"}, done, (c == 20));
        chk({tg, "_rd_en"}, rde, (c <= 17));
        if (c <= 17) chk({tg, "_rd_addr"}, rda, (c + ROWS - 2) % ROWS);
        chk({tg, "_wr_en"}, wre, (c >= 5 && c <= 19));
        if (wre) nwr[d]++;
        if (wre && c >= 5 && c <= 19) begin
          chk({tg, "_wr_addr"}, wra, c - 5);
          chk({tg, "_wr_data"}, wrd, exp_r[d][c-5]);
          wr_cap[d][c-5] = wrd;
        end
      end
      if (c == abort_at) begin
        rst_n = 1'b0;
        #1;
        chk_idle_outputs({name, "_abort"});
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          chk($sformatf("%s_abort_quiet%0d_done", name, k), w_done | z_done, 0);
          chk($sformatf("%s_abort_quiet%0d_strobes", name, k),
              {w_rd_en, w_wr_en, z_rd_en, z_wr_en}, 0);
        end
        rst_n = 1'b1;
        return;
      end
    end
    chk({name, "_w_writes"}, nwr[0], 15);
    chk({name, "_z_writes"}, nwr[1], 15);
  endtask

  initial begin
    for (int r = 0; r < ROWS; r++) grid[r] = '0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_idle_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Blinker
    for (int r = 0; r < ROWS; r++) grid[r] = '0;
    grid[6] = 20'h00700;
    run_gen("blinker", 1'b0, 0);
    for (int r = 0; r < ROWS; r++)
      chk($sformatf("blinker_row%0d", r), wr_cap[0][r],
          (r >= 5 && r <= 7) ? 20'h00200 : 20'h00000);

    // Block still life
    for (int r = 0; r < ROWS; r++) grid[r] = '0;
    grid[3] = 20'h0000C;
    grid[4] = 20'h0000C;
    run_gen("block", 1'b0, 0);
    for (int r = 0; r < ROWS; r++) begin
      chk($sformatf("block_w_row%0d", r), wr_cap[0][r], grid[r]);
      chk($sformatf("block_z_row%0d", r), wr_cap[1][r], grid[r]);
    end

    // Toroidal glider, four generations fed back from the wrap instance
    for (int r = 0; r < ROWS; r++) grid[r] = '0;
    grid[13][19] = 1'b1;
    grid[14][0]  = 1'b1;
    grid[0][18]  = 1'b1;
    grid[0][19]  = 1'b1;
    grid[0][0]   = 1'b1;
    for (int r = 0; r < ROWS; r++) orig[r] = grid[r];
    for (int g = 0; g < 4; g++) begin
      run_gen($sformatf("glider%0d", g), 1'b0, 0);
      for (int r = 0; r < ROWS; r++) grid[r] = wr_cap[0][r];
    end
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        chk($sformatf("glider_shift_r%0d_c%0d", (r + 1) % ROWS, (c + 1) % COLS),
            grid[(r + 1) % ROWS][(c + 1) % COLS], orig[r][c]);

    // All ones
    for (int r = 0; r < ROWS; r++) grid[r] = '1;
    run_gen("ones", 1'b0, 0);
    for (int r = 0; r < ROWS; r++) begin
      chk($sformatf("ones_w_row%0d", r), wr_cap[0][r], 20'h00000);
      chk($sformatf("ones_z_row%0d", r), wr_cap[1][r],
          (r == 0 || r == ROWS - 1) ? 20'h80001 : 20'h00000);
    end

    // Starts while busy are ignored; the one on cycle 21 is accepted
    for (int r = 0; r < ROWS; r++) grid[r] = COLS'($urandom);
    run_gen("glitch", 1'b1, 0);
    for (int r = 0; r < ROWS; r++) grid[r] = COLS'($urandom);
    run_gen("after_glitch", 1'b0, 0);

    // Reset in the middle of RUN, then a full generation
    for (int r = 0; r < ROWS; r++) grid[r] = COLS'($urandom);
    run_gen("abort", 1'b0, 10);
    run_gen("after_abort", 1'b0, 0);

    // Random grids of varying density
    for (int t = 0; t < 8; t++) begin
      for (int r = 0; r < ROWS; r++) begin
        grid[r] = COLS'($urandom);
        if (t[0]) grid[r] = grid[r] & COLS'($urandom);
      end
      run_gen($sformatf("rand%0d", t), 1'b0, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
